// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
// Request/status bundle between the vending controller and the change
// dispenser.
//   change_valid / change_amt / change_ready : one change request per transaction
//   coin_code     : one-cycle echo of each confirmed coin (00 none, 01=1, 10=5, 11=10)
//   remaining     : change still owed
//   busy          : transaction in progress
//   dispense_done : one-cycle pulse when the full amount has been paid
//   dispense_err  : held high while the dispenser sits in its error state
// Modports: master = vending controller, slave = change dispenser.
// -----------------------------------------------------------------------------
interface change_dispenser_if;
   logic       change_valid;
   logic [4:0] change_amt;
   logic       change_ready;
   logic [1:0] coin_code;
   logic [4:0] remaining;
   logic       busy;
   logic       dispense_done;
   logic       dispense_err;

   modport master (
      output change_valid, change_amt,
      input  change_ready, coin_code, remaining, busy, dispense_done, dispense_err
   );

   modport slave (
      input  change_valid, change_amt,
      output change_ready, coin_code, remaining, busy, dispense_done, dispense_err
   );
endinterface

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Pays out a change request greedily in 10/5/1 coins, one hopper pulse per
// coin, waiting for the hopper sensor acknowledge before starting the next
// coin. Tracks per-denomination inventory.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : change_dispenser_if.slave (request handshake and status)
//   hopper_pulse : one-hot coin eject [2]=10, [1]=5, [0]=1
//   hopper_ack   : one-hot coin-out sensor, same mapping
//   refill       : reload all inventories (honoured in IDLE or ERROR only)
//   clear_err    : leave ERROR
//   inv_empty    : per-denomination inventory==0 flags
// Optional feature macro CHANGE_DISP_AUDIT_EN adds:
//   total_paid[11:0] : saturating sum of value dispensed since reset
//   coin_count[7:0]  : saturating count of coins ejected since reset
// -----------------------------------------------------------------------------
module change_dispenser #(
   parameter int PULSE_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int INV_W          = 8,
   parameter int INV_INIT       = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   change_dispenser_if.slave  req,
   output logic [2:0]         hopper_pulse,
   input  logic [2:0]         hopper_ack,
   input  logic               refill,
   input  logic               clear_err,
   output logic [2:0]         inv_empty
`ifdef CHANGE_DISP_AUDIT_EN
   ,output logic [11:0]       total_paid,
   output logic [7:0]         coin_count
`endif
);

   localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [INV_W-1:0] INV_RST      = INV_W'(INV_INIT);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SELECT   = 3'd1,
      S_PULSE    = 3'd2,
      S_WAIT_ACK = 3'd3,
      S_DONE     = 3'd4,
      S_ERROR    = 3'd5
   } state_t;

   // Coin value for a one-hot hopper selection.
   function automatic logic [4:0] denom_of(input logic [2:0] sel);
      case (sel)
         3'b100:  denom_of = 5'd10;
         3'b010:  denom_of = 5'd5;
         3'b001:  denom_of = 5'd1;
         default: denom_of = 5'd0;
      endcase
   endfunction

   // coin_in-style encoding of a one-hot hopper selection.
   function automatic logic [1:0] code_of(input logic [2:0] sel);
      case (sel)
         3'b100:  code_of = 2'b11;
         3'b010:  code_of = 2'b10;
         3'b001:  code_of = 2'b01;
         default: code_of = 2'b00;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic             ready_q, ready_d;
   logic [4:0]       rem_q, rem_d;
   logic [2:0]       sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       pulse_q, pulse_d;
   logic [1:0]       code_q, code_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [INV_W-1:0] inv_q [3];
   logic [INV_W-1:0] inv_d [3];
   logic [2:0]       empty_q, empty_d;
   logic             accept_s;
   logic             ack_s;
   logic             coin_s;
   logic             refill_s;

   // Next-state and next-output computation for the payout sequencer.
   always_comb begin
      accept_s = req.change_valid & ready_q;
      // Only the selected hopper's sensor bit can confirm a coin.
      ack_s    = |(hopper_ack & sel_q);
      coin_s   = 1'b0;
      refill_s = refill & ((state_q == S_IDLE) | (state_q == S_ERROR));
      state_d  = state_q;
      rem_d    = rem_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      code_d   = 2'b00;
      for (int i = 0; i < 3; i++) begin
         inv_d[i] = inv_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               rem_d   = req.change_amt;
               state_d = (req.change_amt == 5'd0) ? S_DONE : S_SELECT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SELECT: begin
            cnt_d = '0;
            if ((rem_q >= 5'd10) && (inv_q[2] != '0)) begin
               sel_d = 3'b100;
            end else if ((rem_q >= 5'd5) && (inv_q[1] != '0)) begin
               sel_d = 3'b010;
            end else if ((rem_q >= 5'd1) && (inv_q[0] != '0)) begin
               sel_d = 3'b001;
            end else begin
               sel_d = 3'b000;
            end
            state_d = (sel_d == 3'b000) ? S_ERROR : S_PULSE;
         end
         S_PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT_ACK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_ACK: begin
            if (ack_s) begin
               coin_s = 1'b1;
               rem_d  = rem_q - denom_of(sel_q);
               code_d = code_of(sel_q);
               for (int i = 0; i < 3; i++) begin
                  inv_d[i] = sel_q[i] ? (inv_q[i] - INV_W'(1)) : inv_q[i];
               end
               state_d = (rem_d != 5'd0) ? S_SELECT : S_DONE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERROR: begin
            // remaining holds the unpaid amount until the error is cleared
            if (clear_err) begin
               state_d = S_IDLE;
               rem_d   = 5'd0;
            end else begin
               state_d = S_ERROR;
            end
         end
         default: begin
            state_d = S_IDLE;
            rem_d   = 5'd0;
            sel_d   = 3'b000;
            cnt_d   = '0;
         end
      endcase

      for (int i = 0; i < 3; i++) begin
         inv_d[i]   = refill_s ? INV_RST : inv_d[i];
         empty_d[i] = (inv_d[i] == '0);
      end

      // ready drops for the cycle after any return to IDLE, so a DONE pass
      // keeps it low for two cycles in total.
      ready_d = (state_q == S_IDLE) & ~accept_s;
      pulse_d = (state_d == S_PULSE) ? sel_d : 3'b000;
      busy_d  = (state_d == S_SELECT) | (state_d == S_PULSE) |
                (state_d == S_WAIT_ACK) | (state_d == S_DONE);
      done_d  = (state_q == S_DONE);
      err_d   = (state_d == S_ERROR);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         rem_q   <= 5'd0;
         sel_q   <= 3'b000;
         cnt_q   <= '0;
         pulse_q <= 3'b000;
         code_q  <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         empty_q <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            inv_q[i] <= INV_RST;
         end
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         rem_q   <= rem_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         code_q  <= code_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         empty_q <= empty_d;
         for (int i = 0; i < 3; i++) begin
            inv_q[i] <= inv_d[i];
         end
      end
   end

   assign req.change_ready  = ready_q;
   assign req.coin_code     = code_q;
   assign req.remaining     = rem_q;
   assign req.busy          = busy_q;
   assign req.dispense_done = done_q;
   assign req.dispense_err  = err_q;
   assign hopper_pulse      = pulse_q;
   assign inv_empty         = empty_q;

`ifdef CHANGE_DISP_AUDIT_EN
   logic [11:0] paid_q, paid_d;
   logic [7:0]  coins_q, coins_d;
   logic [12:0] paid_sum_s;

   // Saturating audit counters, advanced on each confirmed coin.
   always_comb begin
      paid_sum_s = {1'b0, paid_q} + {8'd0, denom_of(sel_q)};
      if (coin_s) begin
         paid_d  = paid_sum_s[12] ? 12'hFFF : paid_sum_s[11:0];
         coins_d = (coins_q == 8'hFF) ? coins_q : (coins_q + 8'd1);
      end else begin
         paid_d  = paid_q;
         coins_d = coins_q;
      end
   end

   // Audit counter flops; cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         paid_q  <= 12'd0;
         coins_q <= 8'd0;
      end else begin
         paid_q  <= paid_d;
         coins_q <= coins_d;
      end
   end

   assign total_paid = paid_q;
   assign coin_count = coins_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Scoreboard bench: each request pushes its expected coin sequence (coin code
// and remaining after the coin) plus a final done entry; a negedge monitor
// pops and compares as the dispenser reports coins and completion. A hopper
// responder acknowledges pulses, optionally never or after a wrong-bit ack.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

   localparam int P_CYC = 4;
   localparam int T_CYC = 255;
   localparam int K_DONE = 4;

   typedef struct {
      int kind;
      int rem;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] hopper_pulse;
   logic [2:0] hopper_ack;
   logic       refill;
   logic       clear_err;
   logic [2:0] inv_empty;
`ifdef CHANGE_DISP_AUDIT_EN
   logic [11:0] total_paid;
   logic [7:0]  coin_count;
`endif

   change_dispenser_if rq ();

   change_dispenser dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (rq.slave),
      .hopper_pulse (hopper_pulse),
      .hopper_ack   (hopper_ack),
      .refill       (refill),
      .clear_err    (clear_err),
      .inv_empty    (inv_empty)
`ifdef CHANGE_DISP_AUDIT_EN
      ,.total_paid  (total_paid),
      .coin_count   (coin_count)
`endif
   );

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t mon_e;
   int   done_cnt = 0;
   int   pulse_cnt [3];
   int   m_inv [3];
   int   ack_mode = 0;       // 0 normal, 1 never ack, 2 wrong bit first
   int   wrong_exp_rem = 0;
   logic [2:0] prev_pulse;
   logic [2:0] fell;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Greedy payout model: pushes expected coins and a done entry.
   function automatic void model_push(input int amt);
      int rem;
      exp_t e;
      rem = amt;
      while (rem > 0) begin
         if (rem >= 10 && m_inv[2] > 0) begin
            rem -= 10; m_inv[2]--; e.kind = 3;
         end else if (rem >= 5 && m_inv[1] > 0) begin
            rem -= 5; m_inv[1]--; e.kind = 2;
         end else begin
            rem -= 1; m_inv[0]--; e.kind = 1;
         end
         e.rem = rem;
         sb.push_back(e);
      end
      e.kind = K_DONE;
      e.rem  = 0;
      sb.push_back(e);
   endfunction

   function automatic int model_empty();
      int v;
      v = 0;
      for (int i = 0; i < 3; i++) begin
         if (m_inv[i] == 0) v |= (1 << i);
      end
      return v;
   endfunction

   // Monitor: compares reported coins and completions against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rq.coin_code != 2'b00) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_coin", int'(rq.coin_code), 0);
            end else begin
               mon_e = sb.pop_front();
               check_eq("coin_code", int'(rq.coin_code), mon_e.kind);
               check_eq("coin_rem", int'(rq.remaining), mon_e.rem);
            end
         end
         if (rq.dispense_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check_eq("unexpected_done", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check_eq("done_kind", K_DONE, mon_e.kind);
               check_eq("done_rem", int'(rq.remaining), 0);
            end
         end
      end
   end

   // Hopper model: counts pulses and acknowledges each finished pulse.
   initial begin
      hopper_ack = 3'b000;
      prev_pulse = 3'b000;
      for (int i = 0; i < 3; i++) pulse_cnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (hopper_pulse[i] && !prev_pulse[i]) pulse_cnt[i]++;
         end
         if (prev_pulse != 3'b000 && hopper_pulse == 3'b000) begin
            fell = prev_pulse;
            prev_pulse = 3'b000;
            if (ack_mode == 0) begin
               @(negedge clk);
               @(negedge clk);
               hopper_ack = fell;
               @(negedge clk);
               hopper_ack = 3'b000;
            end else if (ack_mode == 2) begin
               @(negedge clk);
               hopper_ack = {fell[1:0], fell[2]};
               @(negedge clk);
               hopper_ack = 3'b000;
               check_eq("wrong_ack_rem", int'(rq.remaining), wrong_exp_rem);
               check_eq("wrong_ack_code", int'(rq.coin_code), 0);
               @(negedge clk);
               hopper_ack = fell;
               @(negedge clk);
               hopper_ack = 3'b000;
            end
         end else begin
            prev_pulse = hopper_pulse;
         end
      end
   end

   task automatic send(input int amt);
      int n;
      n = 0;
      @(negedge clk);
      rq.change_valid = 1'b1;
      rq.change_amt   = 5'(amt);
      while (!rq.change_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!rq.change_ready) check_eq("send_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      rq.change_valid = 1'b0;
   endtask

   task automatic run_req(input int amt);
      int start;
      int n;
      start = done_cnt;
      n = 0;
      model_push(amt);
      send(amt);
      while (done_cnt == start && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("done_seen", done_cnt - start, 1);
   endtask

   task automatic do_refill(input logic with_clear);
      @(negedge clk);
      refill    = 1'b1;
      clear_err = with_clear;
      @(negedge clk);
      refill    = 1'b0;
      clear_err = 1'b0;
      for (int i = 0; i < 3; i++) m_inv[i] = 20;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got 0 expected 1 (simulation time limit)");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0 [3];
      int d0;
      int n;
      int lowc;
      rst_n = 1'b0;
      refill = 1'b0;
      clear_err = 1'b0;
      rq.change_valid = 1'b0;
      rq.change_amt = 5'd0;
      for (int i = 0; i < 3; i++) m_inv[i] = 20;
      repeat (3) @(negedge clk);
      check_eq("rst_pulse", int'(hopper_pulse), 0);
      check_eq("rst_busy", int'(rq.busy), 0);
      check_eq("rst_err", int'(rq.dispense_err), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", int'(rq.change_ready), 1);
      check_eq("rst_code", int'(rq.coin_code), 0);
      check_eq("rst_rem", int'(rq.remaining), 0);
      check_eq("rst_done", int'(rq.dispense_done), 0);
      check_eq("rst_empty", int'(inv_empty), 0);

      // 15 -> one 10 then one 5
      p0 = pulse_cnt;
      d0 = done_cnt;
      run_req(15);
      repeat (4) @(negedge clk);
      check_eq("r15_p10", pulse_cnt[2] - p0[2], 1);
      check_eq("r15_p5", pulse_cnt[1] - p0[1], 1);
      check_eq("r15_p1", pulse_cnt[0] - p0[0], 0);
      check_eq("r15_done_once", done_cnt - d0, 1);
      check_eq("r15_empty", int'(inv_empty), model_empty());

      // 0 -> immediate done, ready low exactly two cycles
      p0 = pulse_cnt;
      model_push(0);
      send(0);
      lowc = 0;
      @(negedge clk);
      check_eq("r0_done_early", int'(rq.dispense_done), 0);
      if (!rq.change_ready) lowc++;
      @(negedge clk);
      check_eq("r0_done", int'(rq.dispense_done), 1);
      if (!rq.change_ready) lowc++;
      @(negedge clk);
      check_eq("r0_done_len", int'(rq.dispense_done), 0);
      if (!rq.change_ready) lowc++;
      check_eq("r0_ready_low", lowc, 2);
      check_eq("r0_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2]
                              - p0[0] - p0[1] - p0[2], 0);

      // refill then drain the 5-coin hopper
      do_refill(1'b0);
      for (int k = 0; k < 20; k++) begin
         run_req(5);
         if (k == 3) check_eq("four5_empty", int'(inv_empty), 0);
      end
      repeat (3) @(negedge clk);
      check_eq("drain_empty", int'(inv_empty), 3'b010);

      // 7 with no 5-coins -> seven 1-coins
      p0 = pulse_cnt;
      run_req(7);
      repeat (4) @(negedge clk);
      check_eq("r7_p1", pulse_cnt[0] - p0[0], 7);
      check_eq("r7_p5", pulse_cnt[1] - p0[1], 0);
      check_eq("r7_empty", int'(inv_empty), model_empty());

      // 12 never acknowledged -> timeout to ERROR
      ack_mode = 1;
      send(12);
      n = 0;
      while (!rq.dispense_err && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("err_latency", n, 1 + P_CYC + T_CYC);
      check_eq("err_flag", int'(rq.dispense_err), 1);
      check_eq("err_rem", int'(rq.remaining), 12);
      check_eq("err_busy", int'(rq.busy), 0);
      check_eq("err_ready", int'(rq.change_ready), 0);
      ack_mode = 0;
      do_refill(1'b1);
      check_eq("clr_err", int'(rq.dispense_err), 0);
      check_eq("clr_rem", int'(rq.remaining), 0);
      @(negedge clk);
      check_eq("clr_ready", int'(rq.change_ready), 1);
      check_eq("clr_empty", int'(inv_empty), 0);

      // wrong ack bit ignored, then correct ack completes
      ack_mode = 2;
      wrong_exp_rem = 10;
      run_req(10);
      ack_mode = 0;
      check_eq("wrong_empty", int'(inv_empty), model_empty());

      // reset during the first pulse of a 20 request
      ack_mode = 1;
      d0 = done_cnt;
      send(20);
      n = 0;
      while (hopper_pulse == 3'b000 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("mid_pulse_seen", int'(hopper_pulse), 3'b100);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_pulse", int'(hopper_pulse), 0);
      check_eq("mid_rst_busy", int'(rq.busy), 0);
      for (int i = 0; i < 3; i++) m_inv[i] = 20;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("mid_ready", int'(rq.change_ready), 1);
      check_eq("mid_rem", int'(rq.remaining), 0);
      check_eq("mid_no_done", done_cnt - d0, 0);
      check_eq("mid_empty", int'(inv_empty), 0);
      ack_mode = 0;

      // post-reset full request
      p0 = pulse_cnt;
      run_req(31);
      repeat (4) @(negedge clk);
      check_eq("r31_p10", pulse_cnt[2] - p0[2], 3);
      check_eq("r31_p1", pulse_cnt[0] - p0[0], 1);
      check_eq("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
